riscvssc_imem_arbiter: RTL and testbench

//  Merges the core's two instruction-fetch request ports (imemreq0/imemreq1) onto one

---
 rtl/riscvssc_imem_arbiter_pkg.sv | 12 +
 rtl/riscvssc_tag_fifo.sv | 51 +++++
 rtl/riscvssc_imem_arbiter.sv | 83 ++++++++
 tb/tb_riscvssc_imem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscvssc_imem_arbiter_pkg.sv
// Shared constants for the instruction-memory arbiter.
// Message widths match the 32-bit address/data memory messages.
package riscvssc_imem_arbiter_pkg;

   localparam int IMEM_REQ_SZ  = 67;
   localparam int IMEM_RESP_SZ = 35;
   localparam int IMEM_DEPTH   = 4;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/riscvssc_tag_fifo.sv
// Small circular FIFO holding the source port of each outstanding request.
// Push is ignored when full and pop when empty, so count stays in range.
module riscvssc_tag_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Storage, wrapping pointers and occupancy counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop_ok) count <= count + CW'(1);
         else if (pop_ok && !push_ok) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/riscvssc_imem_arbiter.sv
// Round-robin merge of two fetch ports onto one in-order instruction memory.
// A tag FIFO remembers which port issued each request so responses route back.
module riscvssc_imem_arbiter
   import riscvssc_imem_arbiter_pkg::*;
#(
   parameter int REQ_SZ  = IMEM_REQ_SZ,
   parameter int RESP_SZ = IMEM_RESP_SZ,
   parameter int DEPTH   = IMEM_DEPTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [REQ_SZ-1:0]       imemreq0_msg,
   input  logic                    imemreq0_val,
   output logic                    imemreq0_rdy,
   input  logic [REQ_SZ-1:0]       imemreq1_msg,
   input  logic                    imemreq1_val,
   output logic                    imemreq1_rdy,
   output logic [RESP_SZ-1:0]      imemresp0_msg,
   output logic                    imemresp0_val,
   output logic [RESP_SZ-1:0]      imemresp1_msg,
   output logic                    imemresp1_val,
   output logic [REQ_SZ-1:0]       memreq_msg,
   output logic                    memreq_val,
   input  logic                    memreq_rdy,
   input  logic [RESP_SZ-1:0]      memresp_msg,
   input  logic                    memresp_val,
   output logic [$clog2(DEPTH):0]  outstanding,
   output logic                    err
);

   logic grant;
   logic last_grant;
   logic full;
   logic empty;
   logic head;
   logic fire;
   logic pop;

   // Grant selection plus request/response handshakes; all gated by reset.
   always_comb begin
      grant = PORT0;
      if (imemreq0_val && imemreq1_val) grant = ~last_grant;
      else if (imemreq1_val)            grant = PORT1;
      memreq_val    = (imemreq0_val | imemreq1_val) & ~full & reset;
      memreq_msg    = (grant == PORT1) ? imemreq1_msg : imemreq0_msg;
      imemreq0_rdy  = (grant == PORT0) & memreq_rdy & ~full & reset;
      imemreq1_rdy  = (grant == PORT1) & memreq_rdy & ~full & reset;
      fire          = memreq_val & memreq_rdy;
      pop           = memresp_val & ~empty & reset;
      imemresp0_val = pop & (head == PORT0);
      imemresp1_val = pop & (head == PORT1);
      imemresp0_msg = memresp_msg;
      imemresp1_msg = memresp_msg;
   end

   // Round-robin pointer moves only when memory actually takes a request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    last_grant <= PORT1;
      else if (fire) last_grant <= grant;
   end

   // Sticky error: a response with nothing outstanding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    err <= 1'b0;
      else if (memresp_val && empty) err <= 1'b1;
   end

   riscvssc_tag_fifo #(
      .WIDTH (1),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fire),
      .din   (grant),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (outstanding)
   );

endmodule

// File: tb/tb_riscvssc_imem_arbiter.sv
// Directed self-checking bench for riscvssc_imem_arbiter.
// Each task drives one scenario and checks against hand-computed values.
module tb_riscvssc_imem_arbiter;

   localparam int REQ_SZ  = 67;
   localparam int RESP_SZ = 35;
   localparam int DEPTH   = 4;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [REQ_SZ-1:0]  req0_msg = '0;
   logic               req0_val = 1'b0;
   logic               req0_rdy;
   logic [REQ_SZ-1:0]  req1_msg = '0;
   logic               req1_val = 1'b0;
   logic               req1_rdy;
   logic [RESP_SZ-1:0] resp0_msg;
   logic               resp0_val;
   logic [RESP_SZ-1:0] resp1_msg;
   logic               resp1_val;
   logic [REQ_SZ-1:0]  mreq_msg;
   logic               mreq_val;
   logic               mreq_rdy = 1'b0;
   logic [RESP_SZ-1:0] mresp_msg = '0;
   logic               mresp_val = 1'b0;
   logic [2:0]         outstanding;
   logic               err;

   int tests = 0;
   int fails = 0;

   riscvssc_imem_arbiter #(
      .REQ_SZ  (REQ_SZ),
      .RESP_SZ (RESP_SZ),
      .DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imemreq0_msg  (req0_msg),
      .imemreq0_val  (req0_val),
      .imemreq0_rdy  (req0_rdy),
      .imemreq1_msg  (req1_msg),
      .imemreq1_val  (req1_val),
      .imemreq1_rdy  (req1_rdy),
      .imemresp0_msg (resp0_msg),
      .imemresp0_val (resp0_val),
      .imemresp1_msg (resp1_msg),
      .imemresp1_val (resp1_val),
      .memreq_msg    (mreq_msg),
      .memreq_val    (mreq_val),
      .memreq_rdy    (mreq_rdy),
      .memresp_msg   (mresp_msg),
      .memresp_val   (mresp_val),
      .outstanding   (outstanding),
      .err           (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_val  = 1'b0;
      req1_val  = 1'b0;
      mreq_rdy  = 1'b0;
      mresp_val = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   function automatic logic [REQ_SZ-1:0] rq(input int port, input int addr);
      return {REQ_SZ'(port) << 40} | REQ_SZ'(addr);
   endfunction

   task automatic test_reset();
      reset     = 1'b0;
      req0_val  = 1'b1;
      req1_val  = 1'b1;
      mreq_rdy  = 1'b1;
      mresp_val = 1'b1;
      step();
      tests++;
      if ({mreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val} !== 5'b0) begin
         fails++;
         $display("FAIL reset_outs got %b exp 00000",
            {mreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val});
      end
      tests++;
      if ({outstanding, err} !== 4'b0) begin
         fails++;
         $display("FAIL reset_state got occ=%0d err=%b exp 0 0", outstanding, err);
      end
      idle_inputs();
      reset = 1'b1;
      step();
   endtask

   task automatic test_port0_only();
      int p0 = 0;
      int p1 = 0;
      int peak = 0;
      mreq_rdy = 1'b1;
      req0_val = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req0_msg = rq(0, 4 * i);
         #1;
         tests++;
         if ({req0_rdy, req1_rdy} !== 2'b10 || mreq_msg !== req0_msg) begin
            fails++;
            $display("FAIL p0_issue%0d got rdy=%b%b msg=%h exp rdy=10 msg=%h",
               i, req0_rdy, req1_rdy, mreq_msg, req0_msg);
         end
         step();
         if (int'(outstanding) > peak) peak = int'(outstanding);
      end
      req0_val = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mresp_val = 1'b1;
         mresp_msg = RESP_SZ'(32'h100 + i);
         #1;
         if (resp0_val === 1'b1 && resp0_msg === mresp_msg) p0++;
         if (resp1_val !== 1'b0) p1++;
         step();
      end
      mresp_val = 1'b0;
      #1;
      tests++;
      if (p0 != 3 || p1 != 0) begin
         fails++;
         $display("FAIL p0_resp got p0=%0d p1=%0d exp 3 0", p0, p1);
      end
      tests++;
      if (peak != 3 || outstanding !== 3'd0) begin
         fails++;
         $display("FAIL p0_occ got peak=%0d end=%0d exp 3 0", peak, outstanding);
      end
   endtask

   task automatic test_alternate();
      logic exp_g;
      do_reset();
      mreq_rdy = 1'b1;
      req0_val = 1'b1;
      req1_val = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req0_msg = rq(0, 16 * i);
         req1_msg = rq(1, 16 * i);
         exp_g = logic'(i % 2);
         #1;
         tests++;
         if ({req0_rdy, req1_rdy} !== {~exp_g, exp_g} ||
             mreq_msg !== (exp_g ? req1_msg : req0_msg)) begin
            fails++;
            $display("FAIL alt_grant%0d got rdy=%b%b exp port %0d",
               i, req0_rdy, req1_rdy, exp_g);
         end
         step();
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         exp_g = logic'(i % 2);
         mresp_val = 1'b1;
         mresp_msg = RESP_SZ'(32'h200 + i);
         #1;
         tests++;
         if ({resp0_val, resp1_val} !== {~exp_g, exp_g}) begin
            fails++;
            $display("FAIL alt_route%0d got vals=%b%b exp port %0d",
               i, resp0_val, resp1_val, exp_g);
         end
         step();
      end
      mresp_val = 1'b0;
   endtask

   task automatic test_stall();
      int bad = 0;
      req0_msg = rq(0, 32'h40);
      req1_msg = rq(1, 32'h80);
      req0_val = 1'b1;
      req1_val = 1'b1;
      mreq_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if ({req0_rdy, req1_rdy} !== 2'b00 || mreq_val !== 1'b1 ||
             outstanding !== 3'd0) bad++;
         step();
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL stall_hold got %0d bad cycles exp 0", bad);
      end
      mreq_rdy = 1'b1;
      #1;
      tests++;
      if ({req0_rdy, req1_rdy} !== 2'b10 || mreq_msg !== req0_msg) begin
         fails++;
         $display("FAIL stall_release got rdy=%b%b exp 10", req0_rdy, req1_rdy);
      end
      step();
      tests++;
      if ({req0_rdy, req1_rdy} !== 2'b01 || outstanding !== 3'd1) begin
         fails++;
         $display("FAIL stall_next got rdy=%b%b occ=%0d exp 01 1",
            req0_rdy, req1_rdy, outstanding);
      end
      idle_inputs();
      mresp_val = 1'b1;
      #1;
      tests++;
      if ({resp0_val, resp1_val} !== 2'b10) begin
         fails++;
         $display("FAIL stall_resp got %b%b exp 10", resp0_val, resp1_val);
      end
      step();
      mresp_val = 1'b0;
   endtask

   task automatic test_full();
      do_reset();
      mreq_rdy = 1'b1;
      req0_val = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req0_msg = rq(0, 32'h300 + 4 * i);
         step();
      end
      #1;
      tests++;
      if (outstanding !== 3'd4 || {mreq_val, req0_rdy, req1_rdy} !== 3'b000) begin
         fails++;
         $display("FAIL full_block got occ=%0d val/rdy=%b exp 4 000",
            outstanding, {mreq_val, req0_rdy, req1_rdy});
      end
      mresp_val = 1'b1;
      #1;
      tests++;
      if ({mreq_val, req0_rdy, resp0_val} !== 3'b001) begin
         fails++;
         $display("FAIL full_pop_only got %b exp 001",
            {mreq_val, req0_rdy, resp0_val});
      end
      step();
      mresp_val = 1'b0;
      #1;
      tests++;
      if (outstanding !== 3'd3 || {mreq_val, req0_rdy} !== 2'b11) begin
         fails++;
         $display("FAIL full_after_pop got occ=%0d %b exp 3 11",
            outstanding, {mreq_val, req0_rdy});
      end
      step();
      req0_val = 1'b0;
      mresp_val = 1'b1;
      step();
      req0_val = 1'b1;
      #1;
      tests++;
      if (outstanding !== 3'd3 || {mreq_val, resp0_val} !== 2'b11) begin
         fails++;
         $display("FAIL pushpop_pre got occ=%0d %b exp 3 11",
            outstanding, {mreq_val, resp0_val});
      end
      step();
      tests++;
      if (outstanding !== 3'd3) begin
         fails++;
         $display("FAIL pushpop_occ got %0d exp 3", outstanding);
      end
      req0_val = 1'b0;
      for (int i = 0; i < 3; i++) step();
      mresp_val = 1'b0;
      #1;
      tests++;
      if (outstanding !== 3'd0) begin
         fails++;
         $display("FAIL full_drain got %0d exp 0", outstanding);
      end
   endtask

   task automatic test_err();
      do_reset();
      mresp_val = 1'b1;
      #1;
      tests++;
      if ({resp0_val, resp1_val, err} !== 3'b000) begin
         fails++;
         $display("FAIL err_resp got %b exp 000", {resp0_val, resp1_val, err});
      end
      step();
      mresp_val = 1'b0;
      step();
      step();
      mreq_rdy = 1'b1;
      req0_val = 1'b1;
      step();
      req0_val = 1'b0;
      mresp_val = 1'b1;
      step();
      mresp_val = 1'b0;
      #1;
      tests++;
      if (err !== 1'b1 || outstanding !== 3'd0) begin
         fails++;
         $display("FAIL err_sticky got err=%b occ=%0d exp 1 0", err, outstanding);
      end
   endtask

   task automatic test_async_reset();
      mreq_rdy = 1'b1;
      req0_val = 1'b1;
      for (int i = 0; i < 3; i++) step();
      req1_val = 1'b1;
      mresp_val = 1'b1;
      #1;
      tests++;
      if (outstanding !== 3'd3 || resp0_val !== 1'b1) begin
         fails++;
         $display("FAIL ar_pre got occ=%0d rv=%b exp 3 1", outstanding, resp0_val);
      end
      #1;
      reset = 1'b0;
      #1;
      tests++;
      if ({mreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, err} !== 6'b0 ||
          outstanding !== 3'd0) begin
         fails++;
         $display("FAIL ar_async got %b occ=%0d exp 000000 0",
            {mreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, err}, outstanding);
      end
      step();
      mresp_val = 1'b0;
      reset = 1'b1;
      #1;
      tests++;
      if ({req0_rdy, req1_rdy} !== 2'b10) begin
         fails++;
         $display("FAIL ar_first_grant got %b%b exp 10", req0_rdy, req1_rdy);
      end
      step();
      idle_inputs();
   endtask

   initial begin
      #2;
      test_reset();
      test_port0_only();
      test_alternate();
      test_stall();
      test_full();
      test_err();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
